// File: rtl/seven_seg_scan_mux_if.sv
// Bus between the seven-segment scan multiplexer and whoever feeds it digits.
// The slave modport is the scanner side; the master modport is the digit producer.
interface seven_seg_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    // load is a one-cycle strobe with no ready: every rising edge with load high
    // captures digits_in, and a later strobe before the frame boundary replaces it.
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [3:0]              digit_data;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_done;

    modport master (
        output enable, load, digits_in,
        input  digit_data, digit_sel, digit_idx, frame_done
    );

    modport slave (
        input  enable, load, digits_in,
        output digit_data, digit_sel, digit_idx, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed digit scanner feeding a 4-bit-to-7-segment decoder, with tear-free
// frame-boundary updates. Define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank leading zeros.
module seven_seg_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 100000
) (
    input logic                 clk,
    input logic                 rst,
    seven_seg_scan_mux_if.slave scan
);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int WORD_W = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);

    logic [CNT_W-1:0]      r_count;
    logic [IDX_W-1:0]      r_idx;
    logic [WORD_W-1:0]     r_pending;
    logic [WORD_W-1:0]     r_active;
    logic                  r_pending_valid;
    logic [NUM_DIGITS-1:0] r_sel;
    logic [3:0]            r_data;

    logic                  w_tick;
    logic                  w_boundary;
    logic                  w_copy;
    logic [IDX_W-1:0]      w_next_idx;
    logic [WORD_W-1:0]     w_next_active;
    logic                  w_next_pv;
    logic [3:0]            w_next_data;
    logic                  w_blank;

    // r_idx is the scan state: a strict round-robin over the digit slots.
    always_comb begin
        w_tick     = scan.enable && (r_count == CNT_LAST);
        w_boundary = w_tick && (r_idx == IDX_LAST);
        // While disabled nothing is on the glass, so pending may go live right away.
        w_copy     = w_boundary || (!scan.enable && !scan.load);

        w_next_idx = r_idx;
        if (w_tick) begin
            w_next_idx = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end

        w_next_active = r_active;
        if (w_boundary && scan.load) begin
            w_next_active = scan.digits_in;
        end else if (w_copy && r_pending_valid) begin
            w_next_active = r_pending;
        end

        w_next_pv = r_pending_valid;
        if (scan.load && !w_boundary) begin
            w_next_pv = 1'b1;
        end else if (w_copy) begin
            w_next_pv = 1'b0;
        end

        w_next_data = w_next_active[{w_next_idx, 2'b00} +: 4];
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] w_zero_from;
    logic                  w_acc;

    // w_zero_from[k] is set when digits k..NUM_DIGITS-1 of the next active word are all zero.
    always_comb begin
        w_zero_from = '0;
        w_acc       = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_acc          = w_acc && (w_next_active[4*k +: 4] == 4'h0);
            w_zero_from[k] = w_acc;
        end
        w_blank = (w_next_idx != '0) && w_zero_from[w_next_idx];
    end
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count         <= '0;
            r_idx           <= '0;
            r_pending       <= '0;
            r_active        <= '0;
            r_pending_valid <= 1'b0;
            r_sel           <= '1;
            r_data          <= '0;
        end else begin
            if (scan.enable) begin
                r_count <= w_tick ? '0 : r_count + 1'b1;
            end
            r_idx <= w_next_idx;
            if (scan.load) begin
                r_pending <= scan.digits_in;
            end
            r_pending_valid <= w_next_pv;
            r_active        <= w_next_active;
            if (scan.enable && !w_blank) begin
                r_sel  <= ~(SEL_ONE << w_next_idx);
                r_data <= w_next_data;
            end else begin
                r_sel  <= '1;
                r_data <= '0;
            end
        end
    end

    assign scan.digit_sel  = r_sel;
    assign scan.digit_data = r_data;
    assign scan.digit_idx  = r_idx;
    assign scan.frame_done = w_boundary;
endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Directed bench for seven_seg_scan_mux with NUM_DIGITS=4, PRESCALE=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seven_seg_scan_mux;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    seven_seg_scan_mux_if #(.NUM_DIGITS(4)) scan ();

    seven_seg_scan_mux #(
        .NUM_DIGITS(4),
        .PRESCALE  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .scan(scan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {digit_sel, digit_data, digit_idx, frame_done}
    logic [10:0] obs;
    assign obs = {scan.digit_sel, scan.digit_data, scan.digit_idx, scan.frame_done};

    // Expected output vector for a given active word and slot.
    function automatic logic [10:0] f_exp(input logic [15:0] w, input int slot,
                                          input logic blank_all, input logic fd);
        logic [3:0] sel;
        logic [3:0] data;
        logic       lz;
        lz = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        lz = (slot != 0) && ((w >> (4 * slot)) == 16'h0);
`endif
        if (blank_all || lz) begin
            sel  = 4'hF;
            data = 4'h0;
        end else begin
            sel  = ~(4'b0001 << slot);
            data = w[4*slot +: 4];
        end
        return {sel, data, 2'(slot), fd};
    endfunction

    task automatic test_reset();
        logic [10:0] exp_v;
        rst            = 1'b1;
        scan.enable    = 1'b1;
        scan.load      = 1'b0;
        scan.digits_in = 16'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_v = f_exp(16'h0, 0, 1'b1, 1'b0);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got %h exp %h", i, obs, exp_v);
            end
        end
        rst = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            exp_v = f_exp(16'h0, (j / 4) % 4, 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_release cyc=%0d got %h exp %h", j, obs, exp_v);
            end
        end
    endtask

    task automatic test_scan();
        logic [10:0] exp_v;
        logic        found;
        scan.enable    = 1'b0;
        scan.load      = 1'b1;
        scan.digits_in = 16'h1234;
        @(negedge clk);
        scan.load = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs[10:3] !== 8'hF0) begin
            n_fail++;
            $display("FAIL scan_disabled_blank got %h exp f0", obs[10:3]);
        end
        scan.enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (scan.frame_done === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL scan_frame_done_timeout got 0 exp 1");
        end
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            exp_v = f_exp(16'h1234, (c / 4) % 4, 1'b0, (c % 16) == 15);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL scan cyc=%0d got %h exp %h", c, obs, exp_v);
            end
        end
    endtask

    // Starts at slot 0 of a 16'h1234 frame.
    task automatic test_tear_free();
        logic [10:0] exp_v;
        logic [15:0] word;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            word  = (c < 16) ? 16'h1234 : (c < 32) ? 16'h5678 : 16'h9ABC;
            exp_v = f_exp(word, (c / 4) % 4, 1'b0, (c % 16) == 15);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL tear_free cyc=%0d got %h exp %h", c, obs, exp_v);
            end
            scan.load = 1'b1;
            case (c)
                4:       scan.digits_in = 16'hAAAA;
                8:       scan.digits_in = 16'h5678;
                20:      scan.digits_in = 16'h1111;
                31:      scan.digits_in = 16'h9ABC;
                default: scan.load = 1'b0;
            endcase
        end
        scan.load = 1'b0;
    endtask

    // Starts at slot 0 of a 16'h9ABC frame; enable drops at the second cycle of slot 2.
    task automatic test_enable_gating();
        logic [10:0] exp_v;
        logic [15:0] word;
        int          slot;
        logic        blank;
        for (int c = 0; c <= 36; c++) begin
            @(negedge clk);
            word  = (c < 15) ? 16'h9ABC : 16'h0F0F;
            blank = (c >= 10) && (c <= 14);
            if (c < 8)       slot = c / 4;
            else if (c <= 16) slot = 2;
            else             slot = (3 + (c - 17) / 4) % 4;
            exp_v = f_exp(word, slot, blank, (c == 20) || (c == 36));
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL enable_gating cyc=%0d got %h exp %h", c, obs, exp_v);
            end
            if (c == 9)  scan.enable = 1'b0;
            if (c == 14) scan.enable = 1'b1;
            scan.load      = (c == 11);
            scan.digits_in = 16'h0F0F;
        end
        scan.load = 1'b0;
    endtask

    // Starts at slot 0 of a 16'h0F0F frame.
    task automatic test_reset_mid_frame();
        logic [10:0] exp_v;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c >= 14) exp_v = f_exp(16'h0, 0, 1'b1, 1'b0);
            else         exp_v = f_exp(16'h0F0F, c / 4, 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid cyc=%0d got %h exp %h", c, obs, exp_v);
            end
            scan.load      = (c == 12);
            scan.digits_in = 16'h4321;
            rst            = (c == 13) || (c == 14);
        end
        for (int j = 1; j < 20; j++) begin
            @(negedge clk);
            exp_v = f_exp(16'h0, (j / 4) % 4, 1'b0, j == 15);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid_after cyc=%0d got %h exp %h", j, obs, exp_v);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [10:0] exp_v;
        logic        found;
        scan.enable    = 1'b0;
        scan.load      = 1'b1;
        scan.digits_in = 16'h0070;
        @(negedge clk);
        scan.load = 1'b0;
        @(negedge clk);
        scan.enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (scan.frame_done === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL lz_frame_done_timeout got 0 exp 1");
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            exp_v = f_exp(16'h0070, c / 4, 1'b0, c == 15);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL leading_zero cyc=%0d got %h exp %h", c, obs, exp_v);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_scan();
        test_tear_free();
        test_enable_gating();
        test_reset_mid_frame();
        test_leading_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_mux.md
Name: seven_seg_scan_mux

Overview:
- Multi-digit time-multiplexing scanner that sits directly upstream of the 4-bit-to-7-segment decoder.
- Holds a packed word of hex/BCD nibbles and presents one nibble at a time on `digit_data`, which drives the decoder's 4-bit data input.
- Drives a one-hot, active-low digit-select (common-anode enable) in step with it.
- New values are applied only at frame boundaries, so no digit mixes old and new data within a frame.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- PRESCALE, 100000, clock cycles per digit slot (>=2).
- IDX_W, $clog2(NUM_DIGITS), width of the digit index (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  scan enable; low blanks the display and freezes the scan.
- load  in  1  one-cycle strobe; captures digits_in.
- digits_in  in  4*NUM_DIGITS  packed nibbles; [3:0] is digit 0 (rightmost).
- digit_data  out  4  current nibble to the segment decoder.
- digit_sel  out  NUM_DIGITS  active-low one-hot select; bit k selects digit k.
- digit_idx  out  IDX_W  index of the currently driven slot.
- frame_done  out  1  one-cycle pulse when the last slot of a frame ends.

Behaviour:
- **Reset** (rst high at a clock edge): prescale count=0, idx=0, pending=0, active=0, pending_valid=0. Outputs: digit_sel=all ones, digit_data=0, digit_idx=0, frame_done=0. Reset overrides every other input, including reset asserted mid-frame.
- **Registers**: pending word, active word, pending_valid flag, prescale counter (0..PRESCALE-1), slot index.
- **Load**: load=1 at an edge writes digits_in to pending and sets pending_valid.
  - Loads are not queued; the last load before a frame boundary wins.
  - While enable=0, pending is copied to active on the following edge.
- **Slot tick**: enable=1 and count==PRESCALE-1.
  - count wraps to 0.
  - idx increments; it wraps from NUM_DIGITS-1 to 0.
- **Frame boundary**: a tick with idx==NUM_DIGITS-1.
  - frame_done=1 for that one cycle.
  - If pending_valid, pending is copied to active and pending_valid clears, so the new frame uses the new data.
  - A load in the same cycle as the boundary captures the fresh digits_in, and that value is the one applied.
- **Registered outputs**: digit_sel, digit_data and digit_idx are registered and reflect next-state idx/active.
  - Slot k drives digit_sel with only bit k low, digit_data=active[4k+3:4k] and digit_idx=k.
  - This takes effect from the cycle after the tick that enters slot k.
  - Each slot lasts exactly PRESCALE cycles.
  - After reset with enable=1, slot 0 is driven from the first enabled cycle.
- **enable=0**:
  - count and idx hold.
  - Next cycle: digit_sel=all ones, digit_data=0.
  - frame_done stays 0.
- **Re-enable**: resumes the same slot with its remaining count; outputs are restored on the next cycle.
- **No FSM beyond the counters**: idx acts as the state, with states SLOT_0..SLOT_{NUM_DIGITS-1} in a strict round-robin.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - Any digit k>0 is blanked during its slot (digit_sel all ones, digit_data=0) when active digits k..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - Slot timing, digit_idx and frame_done are unchanged.
- Undefined: every digit is always displayed, including leading zeros.

Test Plan:
- Reset: assert rst for 3 cycles, enable=1 -> digit_sel=4'b1111, digit_data=0, digit_idx=0, frame_done=0 throughout. Release -> slot 0 with data 0.
- Scan (NUM_DIGITS=4, PRESCALE=4): load 16'h1234 while enable=0, then enable=1 -> slots repeat for 4 cycles each:
  - 1110/4
  - 1101/3
  - 1011/2
  - 0111/1

  frame_done pulses exactly once per 16 cycles, on the last cycle of slot 3.
- Tear-free update: load 16'h5678 during slot 1 of a 16'h1234 frame -> slots 2,3 still show 2,1. The next frame shows 8,7,6,5.
- Enable gating: drop enable at cycle 2 of slot 2 for 5 cycles -> digit_sel=1111 from the next cycle, with the count frozen. On re-enable, slot 2 lasts 2 more cycles, then slot 3 follows.
- Reset mid-frame: rst during slot 3 with a pending load -> reset values next cycle. After release the display shows 0000, and the pending value is lost.
- Macro: load 16'h0070, enable=1.
  - Defined: slots 2 and 3 show digit_sel=1111, slot 1 shows 7, slot 0 shows 0.
  - Undefined: all four slots are selected, with data 0,7,0,0.
